// File: rtl/zx_sdram_port_client.sv
// Initiator side of the SDRAM toggle req/ack client port: byte strobes in, 16-bit word requests out.
// Define ZX_SDRAM_CLIENT_CACHE_EN to add a one-word, write-coherent read cache.
module zx_sdram_port_client #(
    parameter logic [7:0] DOUT_RESET = 8'hFF,
    parameter int         ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_dvalid,
    output logic              cpu_busy,
    output logic              port_req,
    input  logic              port_ack,
    output logic              port_we,
    output logic [ADDR_W-2:0] port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q
);
    typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

    state_t            state;
    logic              q_vld, q_we;
    logic [ADDR_W-1:0] q_addr;
    logic [7:0]        q_din;
    logic              cur_lo;

    logic              accept, done, hit;
    logic [7:0]        hit_byte;
    logic              iss_go, iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [7:0]        iss_din;

    assign cpu_busy = (state == SYNC) | q_vld;
    assign accept   = (cpu_rd | cpu_wr) & ~cpu_busy;
    assign done     = (state == WAIT) && (port_ack == port_req);

`ifdef ZX_SDRAM_CLIENT_CACHE_EN
    logic              c_vld, f_vld;
    logic [ADDR_W-2:0] c_tag, f_tag;
    logic [15:0]       c_dat, f_dat;

    // Cache view after this edge's read fill; write coherence is applied on top of it.
    always_comb begin
        f_vld = c_vld;
        f_tag = c_tag;
        f_dat = c_dat;
        if (done && !port_we) begin
            f_vld = 1'b1;
            f_tag = port_a;
            f_dat = port_q;
        end
    end

    assign hit      = (state == IDLE) && accept && !cpu_wr && c_vld &&
                      (c_tag == cpu_addr[ADDR_W-1:1]);
    assign hit_byte = cpu_addr[0] ? c_dat[15:8] : c_dat[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_vld <= 1'b0;
            c_tag <= '0;
            c_dat <= '0;
        end else begin
            c_vld <= f_vld;
            c_tag <= f_tag;
            c_dat <= f_dat;
            if (iss_go && iss_we && f_vld && (f_tag == iss_addr[ADDR_W-1:1])) begin
                if (iss_addr[0]) c_dat[15:8] <= iss_din;
                else             c_dat[7:0]  <= iss_din;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_byte = 8'h00;
`endif

    // The queued request has priority at completion; otherwise a fresh strobe issues
    // from IDLE on a miss, or on the completion edge when the path frees up.
    always_comb begin
        iss_go   = 1'b0;
        iss_we   = cpu_wr;
        iss_addr = cpu_addr;
        iss_din  = cpu_din;
        if (done && q_vld) begin
            iss_go   = 1'b1;
            iss_we   = q_we;
            iss_addr = q_addr;
            iss_din  = q_din;
        end else if (accept && ((state == IDLE) ? !hit : done)) begin
            iss_go = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            q_vld      <= 1'b0;
            q_we       <= 1'b0;
            q_addr     <= '0;
            q_din      <= '0;
            cur_lo     <= 1'b0;
            cpu_dout   <= DOUT_RESET;
            cpu_dvalid <= 1'b0;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_a     <= '0;
            port_ds    <= 2'b00;
            port_d     <= '0;
        end else begin
            cpu_dvalid <= 1'b0;
            case (state)
                SYNC: if (port_ack == port_req) state <= IDLE;
                IDLE: if (hit) begin
                    cpu_dout   <= hit_byte;
                    cpu_dvalid <= 1'b1;
                end
                WAIT: if (done) begin
                    if (!port_we) begin
                        cpu_dout   <= cur_lo ? port_q[15:8] : port_q[7:0];
                        cpu_dvalid <= 1'b1;
                    end
                    if (q_vld)        q_vld <= 1'b0;
                    else if (!accept) state <= IDLE;
                end else if (accept) begin
                    q_vld  <= 1'b1;
                    q_we   <= cpu_wr;
                    q_addr <= cpu_addr;
                    q_din  <= cpu_din;
                end
                default: state <= SYNC;
            endcase
            if (iss_go) begin
                state    <= WAIT;
                port_req <= ~port_req;
                port_we  <= iss_we;
                port_a   <= iss_addr[ADDR_W-1:1];
                cur_lo   <= iss_addr[0];
                if (iss_we) begin
                    port_ds <= iss_addr[0] ? 2'b10 : 2'b01;
                    port_d  <= {iss_din, iss_din};
                end else begin
                    port_ds <= 2'b11;
                end
            end
        end
    end
endmodule
